// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
//   fwd_sel_e   : EX operand source select (register file, WB result, MEM result)
//   stage_rec_t : one in-flight instruction as seen by hazard detection
//   fwd_pick    : priority select between a MEM and a WB producer
package pipe_hazard_ctrl_pkg;

    // Records carry a register address of this width. Narrower addresses are
    // zero-extended into it, so any RA_W up to this value is supported.
    localparam int REC_RA_W = 8;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic                valid;
        logic [REC_RA_W-1:0] rd;
        logic                regwrite;
        logic                memread;
    } stage_rec_t;

    localparam stage_rec_t REC_EMPTY = '0;

    // MEM holds the younger producer, so it wins over WB.
    function automatic fwd_sel_e fwd_pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit) begin
            return FWD_MEM;
        end else if (wb_hit) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives the ID-stage fields and dmem_ready_i
//   slave  : hazard controller, drives the pipeline control outputs
//
// Handshake: id_valid_i qualifies every other id_* field; the ID slot is
// consumed on a cycle where id_valid_i=1 and pc_write_o=1 (no stall, no hold).
// dmem_ready_i is the completion strobe for the access held in MEM: while a
// load sits in MEM with dmem_ready_i=0 the back end is frozen, and the load
// retires from MEM on the first clock edge that sees dmem_ready_i=1.
interface pipe_hazard_ctrl_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
);
    logic            id_valid_i;
    logic [RA_W-1:0] id_rs1_i;
    logic [RA_W-1:0] id_rs2_i;
    logic            id_rs1_used_i;
    logic            id_rs2_used_i;
    logic [RA_W-1:0] id_rd_i;
    logic            id_regwrite_i;
    logic            id_memread_i;
    logic            id_branch_i;
    logic            id_taken_i;
    logic            dmem_ready_i;

    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             pipe_hold_o;
    logic [1:0]       fwd_a_o;
    logic [1:0]       fwd_b_o;
    logic             fwd_br_a_o;
    logic             fwd_br_b_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
               id_rd_i, id_regwrite_i, id_memread_i, id_branch_i, id_taken_i,
               dmem_ready_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
               fwd_a_o, fwd_b_o, fwd_br_a_o, fwd_br_b_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
               id_rd_i, id_regwrite_i, id_memread_i, id_branch_i, id_taken_i,
               dmem_ready_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
               fwd_a_o, fwd_b_o, fwd_br_a_o, fwd_br_b_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hz_match.sv
// hz_match: does one source register depend on one in-flight record?
//   i_src   : source register address
//   i_rec   : stage record (valid, rd, regwrite, memread)
//   o_match : record is valid, writes a register, rd is not x0, rd == i_src
module hz_match
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] i_src,
    input  stage_rec_t      i_rec,
    output logic            o_match
);

    logic [REC_RA_W-1:0] w_src;

    assign w_src   = REC_RA_W'(i_src);
    // x0 is hard-wired zero, so a write to it never creates a dependency.
    assign o_match = i_rec.valid & i_rec.regwrite & (i_rec.rd != '0) & (i_rec.rd == w_src);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall / flush / forwarding control for a 5-stage pipeline.
// Tracks EX, MEM and WB as records and derives all controls combinationally.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   hz (slave)     : ID fields + dmem_ready_i in; pc_write_o, ifid_write_o,
//                    ifid_flush_o, idex_bubble_o, pipe_hold_o, fwd_a/b_o,
//                    fwd_br_a/b_o, stall_cnt_o, flush_cnt_o out
// FWD_EN=1 forwards from MEM/WB; FWD_EN=0 interlocks on every dependency.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RA_W   = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    pipe_hazard_ctrl_if.slave hz
);

    localparam bit C_FWD = (FWD_EN != 0);

    stage_rec_t       r_ex, r_mem, r_wb;
    logic [RA_W-1:0]  r_ex_src  [2];
    logic             r_ex_used [2];
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    stage_rec_t      w_recs    [3];
    logic [RA_W-1:0] w_id_src  [2];
    logic            w_id_used [2];
    logic            w_id_m    [2][3];  // [ID source][EX, MEM, WB]
    logic            w_ex_m_mem[2];
    logic            w_ex_m_wb [2];

    assign w_recs[0]    = r_ex;
    assign w_recs[1]    = r_mem;
    assign w_recs[2]    = r_wb;
    assign w_id_src[0]  = hz.id_rs1_i;
    assign w_id_src[1]  = hz.id_rs2_i;
    assign w_id_used[0] = hz.id_rs1_used_i;
    assign w_id_used[1] = hz.id_rs2_used_i;

    for (genvar s = 0; s < 2; s++) begin : g_src
        for (genvar k = 0; k < 3; k++) begin : g_rec
            hz_match #(.RA_W(RA_W)) u_id_match (
                .i_src(w_id_src[s]), .i_rec(w_recs[k]), .o_match(w_id_m[s][k])
            );
        end
        hz_match #(.RA_W(RA_W)) u_ex_mem_match (
            .i_src(r_ex_src[s]), .i_rec(r_mem), .o_match(w_ex_m_mem[s])
        );
        hz_match #(.RA_W(RA_W)) u_ex_wb_match (
            .i_src(r_ex_src[s]), .i_rec(r_wb), .o_match(w_ex_m_wb[s])
        );
    end

    logic w_hold, w_stall_raw, w_stall, w_flush;

    // A load waiting in MEM freezes the whole back end.
    assign w_hold = r_mem.valid & r_mem.memread & ~hz.dmem_ready_i;

    always_comb begin
        w_stall_raw = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (hz.id_valid_i && w_id_used[s]) begin
                if (C_FWD) begin
                    // Load data exists only after MEM, one cycle too late for EX.
                    if (w_id_m[s][0] && r_ex.memread) begin
                        w_stall_raw = 1'b1;
                    end
                    // Branches compare in ID: only a settled ALU result in MEM
                    // can be forwarded there.
                    if (hz.id_branch_i && (w_id_m[s][0] || (w_id_m[s][1] && r_mem.memread))) begin
                        w_stall_raw = 1'b1;
                    end
                end else if (w_id_m[s][0] || w_id_m[s][1] || w_id_m[s][2]) begin
                    w_stall_raw = 1'b1;
                end
            end
        end
    end

    assign w_stall = w_stall_raw & ~w_hold;
    assign w_flush = hz.id_valid_i & hz.id_branch_i & hz.id_taken_i & ~w_stall & ~w_hold;

    fwd_sel_e w_fwd_a, w_fwd_b;
    logic     w_br_a, w_br_b;

    always_comb begin
        w_fwd_a = FWD_REG;
        w_fwd_b = FWD_REG;
        w_br_a  = 1'b0;
        w_br_b  = 1'b0;
        if (C_FWD) begin
            w_fwd_a = fwd_pick(r_ex_used[0] & w_ex_m_mem[0], r_ex_used[0] & w_ex_m_wb[0]);
            w_fwd_b = fwd_pick(r_ex_used[1] & w_ex_m_mem[1], r_ex_used[1] & w_ex_m_wb[1]);
            w_br_a  = w_id_m[0][1] & ~r_mem.memread;
            w_br_b  = w_id_m[1][1] & ~r_mem.memread;
        end
    end

    assign hz.pc_write_o    = ~(w_stall | w_hold);
    assign hz.ifid_write_o  = ~(w_stall | w_hold);
    assign hz.ifid_flush_o  = w_flush;
    assign hz.idex_bubble_o = w_stall;
    assign hz.pipe_hold_o   = w_hold;
    assign hz.fwd_a_o       = w_fwd_a;
    assign hz.fwd_b_o       = w_fwd_b;
    assign hz.fwd_br_a_o    = w_br_a;
    assign hz.fwd_br_b_o    = w_br_b;
    assign hz.stall_cnt_o   = r_stall_cnt;
    assign hz.flush_cnt_o   = r_flush_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ex         <= REC_EMPTY;
            r_mem        <= REC_EMPTY;
            r_wb         <= REC_EMPTY;
            r_ex_src[0]  <= '0;
            r_ex_src[1]  <= '0;
            r_ex_used[0] <= 1'b0;
            r_ex_used[1] <= 1'b0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (!w_hold) begin
                r_wb  <= r_mem;
                r_mem <= r_ex;
                if (hz.id_valid_i && !w_stall) begin
                    r_ex         <= '{valid: 1'b1, rd: REC_RA_W'(hz.id_rd_i),
                                      regwrite: hz.id_regwrite_i, memread: hz.id_memread_i};
                    r_ex_src[0]  <= hz.id_rs1_i;
                    r_ex_src[1]  <= hz.id_rs2_i;
                    r_ex_used[0] <= hz.id_rs1_used_i;
                    r_ex_used[1] <= hz.id_rs2_used_i;
                end else begin
                    // Bubble: no sources read, so it never asks for forwarding.
                    r_ex         <= REC_EMPTY;
                    r_ex_src[0]  <= '0;
                    r_ex_src[1]  <= '0;
                    r_ex_used[0] <= 1'b0;
                    r_ex_used[1] <= 1'b0;
                end
            end
            if ((w_stall || w_hold) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    localparam int RA_W = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Shared ID / memory stimulus, fed to all three controllers.
    logic            s_valid, s_u1, s_u2, s_rw, s_mr, s_br, s_tk, s_rdy;
    logic [RA_W-1:0] s_rs1, s_rs2, s_rd;

    // 0: forwarding, 1: interlock-only, 2: forwarding with 4-bit counters
    pipe_hazard_ctrl_if #(.RA_W(RA_W), .CNT_W(32)) if0 ();
    pipe_hazard_ctrl_if #(.RA_W(RA_W), .CNT_W(32)) if1 ();
    pipe_hazard_ctrl_if #(.RA_W(RA_W), .CNT_W(4))  if2 ();

    pipe_hazard_ctrl #(.RA_W(RA_W), .FWD_EN(1), .CNT_W(32)) u_fwd (.clk_i(clk), .rst_n_i(rst_n), .hz(if0.slave));
    pipe_hazard_ctrl #(.RA_W(RA_W), .FWD_EN(0), .CNT_W(32)) u_ilk (.clk_i(clk), .rst_n_i(rst_n), .hz(if1.slave));
    pipe_hazard_ctrl #(.RA_W(RA_W), .FWD_EN(1), .CNT_W(4))  u_sat (.clk_i(clk), .rst_n_i(rst_n), .hz(if2.slave));

    assign if0.id_valid_i = s_valid;  assign if1.id_valid_i = s_valid;  assign if2.id_valid_i = s_valid;
    assign if0.id_rs1_i = s_rs1;      assign if1.id_rs1_i = s_rs1;      assign if2.id_rs1_i = s_rs1;
    assign if0.id_rs2_i = s_rs2;      assign if1.id_rs2_i = s_rs2;      assign if2.id_rs2_i = s_rs2;
    assign if0.id_rs1_used_i = s_u1;  assign if1.id_rs1_used_i = s_u1;  assign if2.id_rs1_used_i = s_u1;
    assign if0.id_rs2_used_i = s_u2;  assign if1.id_rs2_used_i = s_u2;  assign if2.id_rs2_used_i = s_u2;
    assign if0.id_rd_i = s_rd;        assign if1.id_rd_i = s_rd;        assign if2.id_rd_i = s_rd;
    assign if0.id_regwrite_i = s_rw;  assign if1.id_regwrite_i = s_rw;  assign if2.id_regwrite_i = s_rw;
    assign if0.id_memread_i = s_mr;   assign if1.id_memread_i = s_mr;   assign if2.id_memread_i = s_mr;
    assign if0.id_branch_i = s_br;    assign if1.id_branch_i = s_br;    assign if2.id_branch_i = s_br;
    assign if0.id_taken_i = s_tk;     assign if1.id_taken_i = s_tk;     assign if2.id_taken_i = s_tk;
    assign if0.dmem_ready_i = s_rdy;  assign if1.dmem_ready_i = s_rdy;  assign if2.dmem_ready_i = s_rdy;

    logic        pcw [3], ifw [3], fl [3], bub [3], hold [3], fba [3], fbb [3];
    logic [1:0]  fa  [3], fb  [3];
    logic [31:0] sc  [3], fc  [3];

    assign pcw[0] = if0.pc_write_o;    assign pcw[1] = if1.pc_write_o;    assign pcw[2] = if2.pc_write_o;
    assign ifw[0] = if0.ifid_write_o;  assign ifw[1] = if1.ifid_write_o;  assign ifw[2] = if2.ifid_write_o;
    assign fl[0]  = if0.ifid_flush_o;  assign fl[1]  = if1.ifid_flush_o;  assign fl[2]  = if2.ifid_flush_o;
    assign bub[0] = if0.idex_bubble_o; assign bub[1] = if1.idex_bubble_o; assign bub[2] = if2.idex_bubble_o;
    assign hold[0] = if0.pipe_hold_o;  assign hold[1] = if1.pipe_hold_o;  assign hold[2] = if2.pipe_hold_o;
    assign fa[0]  = if0.fwd_a_o;       assign fa[1]  = if1.fwd_a_o;       assign fa[2]  = if2.fwd_a_o;
    assign fb[0]  = if0.fwd_b_o;       assign fb[1]  = if1.fwd_b_o;       assign fb[2]  = if2.fwd_b_o;
    assign fba[0] = if0.fwd_br_a_o;    assign fba[1] = if1.fwd_br_a_o;    assign fba[2] = if2.fwd_br_a_o;
    assign fbb[0] = if0.fwd_br_b_o;    assign fbb[1] = if1.fwd_br_b_o;    assign fbb[2] = if2.fwd_br_b_o;
    assign sc[0]  = if0.stall_cnt_o;   assign sc[1]  = if1.stall_cnt_o;   assign sc[2]  = {28'd0, if2.stall_cnt_o};
    assign fc[0]  = if0.flush_cnt_o;   assign fc[1]  = if1.flush_cnt_o;   assign fc[2]  = {28'd0, if2.flush_cnt_o};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist[d][k] is the instruction issued k+1 cycles ago into DUT d
    // (k=0 executing, k=1 in memory, k=2 writing back).
    typedef struct {
        bit v; int rs1; int rs2; bit u1; bit u2; int rd; bit rw; bit mr;
    } ins_t;

    typedef struct {
        bit pcw; bit ifw; bit fl; bit bub; bit hold; int fa; int fb; bit fba; bit fbb;
    } exp_t;

    ins_t   hist    [3][3];
    longint m_stall [3];
    longint m_flush [3];

    function automatic bit writes(input ins_t p, input int r);
        return p.v && p.rw && (p.rd != 0) && (p.rd == r);
    endfunction

    function automatic int src_sel(input ins_t younger, input ins_t older, input int r);
        if (writes(younger, r)) return 2;
        if (writes(older, r)) return 1;
        return 0;
    endfunction

    function automatic exp_t expect_of(input int d, input ins_t id, input bit br, input bit tk, input bit rdy);
        exp_t e;
        bit   need, stall, fwd;
        int   src [2];
        bit   use_s [2];
        ins_t ex, mem, wb;
        ex = hist[d][0]; mem = hist[d][1]; wb = hist[d][2];
        fwd = (d != 1);
        src[0] = id.rs1; src[1] = id.rs2; use_s[0] = id.u1; use_s[1] = id.u2;
        e.hold = mem.v && mem.mr && !rdy;
        need = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (id.v && use_s[s]) begin
                if (fwd) begin
                    if (ex.mr && writes(ex, src[s])) need = 1'b1;
                    if (br && (writes(ex, src[s]) || (mem.mr && writes(mem, src[s])))) need = 1'b1;
                end else if (writes(ex, src[s]) || writes(mem, src[s]) || writes(wb, src[s])) begin
                    need = 1'b1;
                end
            end
        end
        stall  = need && !e.hold;
        e.bub  = stall;
        e.pcw  = !(stall || e.hold);
        e.ifw  = e.pcw;
        e.fl   = id.v && br && tk && !stall && !e.hold;
        e.fa   = (fwd && ex.v && ex.u1) ? src_sel(mem, wb, ex.rs1) : 0;
        e.fb   = (fwd && ex.v && ex.u2) ? src_sel(mem, wb, ex.rs2) : 0;
        e.fba  = fwd && !mem.mr && writes(mem, id.rs1);
        e.fbb  = fwd && !mem.mr && writes(mem, id.rs2);
        return e;
    endfunction

    always @(negedge clk) begin : p_compare
        ins_t   id, empty;
        exp_t   e;
        longint cap;
        empty = '{default: 0};
        id = '{v: s_valid, rs1: int'(s_rs1), rs2: int'(s_rs2), u1: s_u1, u2: s_u2,
               rd: int'(s_rd), rw: s_rw, mr: s_mr};
        for (int d = 0; d < 3; d++) begin
            cap = (d == 2) ? 64'd15 : 64'hFFFF_FFFF;
            if (!rst_n) begin
                for (int k = 0; k < 3; k++) hist[d][k] = empty;
                m_stall[d] = 0;
                m_flush[d] = 0;
            end
            e = expect_of(d, id, s_br, s_tk, s_rdy);
            chk($sformatf("dut%0d.pc_write", d), 64'(pcw[d]), 64'(e.pcw));
            chk($sformatf("dut%0d.ifid_write", d), 64'(ifw[d]), 64'(e.ifw));
            chk($sformatf("dut%0d.ifid_flush", d), 64'(fl[d]), 64'(e.fl));
            chk($sformatf("dut%0d.idex_bubble", d), 64'(bub[d]), 64'(e.bub));
            chk($sformatf("dut%0d.pipe_hold", d), 64'(hold[d]), 64'(e.hold));
            chk($sformatf("dut%0d.fwd_a", d), 64'(fa[d]), 64'(e.fa));
            chk($sformatf("dut%0d.fwd_b", d), 64'(fb[d]), 64'(e.fb));
            chk($sformatf("dut%0d.fwd_br_a", d), 64'(fba[d]), 64'(e.fba));
            chk($sformatf("dut%0d.fwd_br_b", d), 64'(fbb[d]), 64'(e.fbb));
            chk($sformatf("dut%0d.stall_cnt", d), 64'(sc[d]), 64'(m_stall[d]));
            chk($sformatf("dut%0d.flush_cnt", d), 64'(fc[d]), 64'(m_flush[d]));
            if (rst_n) begin
                if (!e.hold) begin
                    hist[d][2] = hist[d][1];
                    hist[d][1] = hist[d][0];
                    hist[d][0] = (id.v && !e.bub) ? id : empty;
                end
                if ((e.bub || e.hold) && m_stall[d] < cap) m_stall[d]++;
                if (e.fl && m_flush[d] < cap) m_flush[d]++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit rw, input bit mr, input bit br, input bit tk);
        s_valid = v; s_rs1 = RA_W'(rs1); s_u1 = u1; s_rs2 = RA_W'(rs2); s_u2 = u2;
        s_rd = RA_W'(rd); s_rw = rw; s_mr = mr; s_br = br; s_tk = tk;
    endtask

    task automatic idle();                             set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic lw(input int rd);                   set_id(1, 0, 0, 0, 0, rd, 1, 1, 0, 0); endtask
    task automatic alu(input int rd, input int a, input int b); set_id(1, a, 1, b, 1, rd, 1, 0, 0, 0); endtask
    task automatic branch(input int a, input int b, input bit tk); set_id(1, a, 1, b, 1, 0, 0, 0, 1, tk); endtask

    task automatic do_reset();
        idle();
        s_rdy = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        s_rdy = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset.pc_write", 64'(pcw[0]), 64'd1);
        chk("reset.ifid_write", 64'(ifw[1]), 64'd1);
        chk("reset.bubble", 64'(bub[0]), 64'd0);
        chk("reset.hold", 64'(hold[2]), 64'd0);
        chk("reset.stall_cnt", 64'(sc[0]), 64'd0);
        step();
        rst_n = 1'b1;

        // Load-use: one stall, then the consumer takes the load from WB
        do_reset();
        lw(5);          @(negedge clk); chk("lu.first_pcw", 64'(pcw[0]), 64'd1); step();
        alu(6, 5, 1);   @(negedge clk); chk("lu.bubble", 64'(bub[0]), 64'd1);
                                        chk("lu.pcw", 64'(pcw[0]), 64'd0); step();
                        @(negedge clk); chk("lu.released", 64'(bub[0]), 64'd0);
                                        chk("lu.stall_cnt", 64'(sc[0]), 64'd1); step();
        idle();         @(negedge clk); chk("lu.fwd_a_wb", 64'(fa[0]), 64'd1);
                                        chk("lu.fwd_b_reg", 64'(fb[0]), 64'd0); step();

        // Back-to-back ALU forwarding
        do_reset();
        alu(3, 1, 2);   step();
        alu(4, 3, 3);   @(negedge clk); chk("alu.no_stall", 64'(pcw[0]), 64'd1); step();
        alu(5, 3, 4);   @(negedge clk); chk("alu.fwd_a_mem", 64'(fa[0]), 64'd2);
                                        chk("alu.fwd_b_mem", 64'(fb[0]), 64'd2);
                                        chk("alu.ilk_fwd_a", 64'(fa[1]), 64'd0); step();
        idle();         @(negedge clk); chk("alu.third_fwd_a", 64'(fa[0]), 64'd1);
                                        chk("alu.third_fwd_b", 64'(fb[0]), 64'd2); step();

        // Taken branch, independent then dependent on an EX add
        do_reset();
        branch(1, 2, 1); @(negedge clk); chk("br.flush", 64'(fl[0]), 64'd1); step();
        idle();          @(negedge clk); chk("br.flush_once", 64'(fl[0]), 64'd0);
                                         chk("br.flush_cnt", 64'(fc[0]), 64'd1); step();
        do_reset();
        alu(1, 2, 3);    step();
        branch(1, 2, 1); @(negedge clk); chk("brdep.stall", 64'(bub[0]), 64'd1);
                                         chk("brdep.no_flush", 64'(fl[0]), 64'd0); step();
                         @(negedge clk); chk("brdep.flush", 64'(fl[0]), 64'd1);
                                         chk("brdep.fwd_br_a", 64'(fba[0]), 64'd1); step();
        idle();          @(negedge clk); chk("brdep.flush_cnt", 64'(fc[0]), 64'd1);
                                         chk("brdep.stall_cnt", 64'(sc[0]), 64'd1); step();

        // Memory wait: three held cycles with the load frozen in MEM
        do_reset();
        lw(2);  step();
        idle(); step();
        s_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold.active", 64'(hold[0]), 64'd1);
            chk("hold.pcw", 64'(pcw[0]), 64'd0);
            chk("hold.no_bubble", 64'(bub[0]), 64'd0);
            step();
        end
        s_rdy = 1'b1;
        branch(2, 0, 0); @(negedge clk); chk("hold.released", 64'(hold[0]), 64'd0);
                                         chk("hold.stall_cnt", 64'(sc[0]), 64'd3);
                                         chk("hold.load_still_mem", 64'(bub[0]), 64'd1); step();
        idle(); step();

        // Interlock-only: three stall cycles, x0 never stalls
        do_reset();
        alu(7, 1, 2); step();
        alu(8, 7, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ilk.stall", 64'(bub[1]), 64'd1);
            chk("ilk.fwd_a", 64'(fa[1]), 64'd0);
            if (i == 1) chk("ilk.fwd_peer_mem", 64'(fa[0]), 64'd2);
            step();
        end
        @(negedge clk); chk("ilk.release", 64'(pcw[1]), 64'd1);
                        chk("ilk.stall_cnt", 64'(sc[1]), 64'd3); step();
        do_reset();
        alu(0, 1, 2); step();
        alu(9, 0, 0); @(negedge clk); chk("x0.no_stall", 64'(pcw[1]), 64'd1); step();

        // Saturation and reset in the middle of a hold
        do_reset();
        lw(2);  step();
        idle(); step();
        s_rdy = 1'b0;
        repeat (20) step();
        @(negedge clk);
        chk("sat.cnt4", 64'(sc[2]), 64'd15);
        chk("sat.cnt32", 64'(sc[0]), 64'd20);
        chk("sat.hold", 64'(hold[2]), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst.cnt", 64'(sc[0]), 64'd0);
        chk("midrst.cnt4", 64'(sc[2]), 64'd0);
        chk("midrst.hold", 64'(hold[0]), 64'd0);
        chk("midrst.pcw", 64'(pcw[0]), 64'd1);
        @(posedge clk);
        #1;
        s_rdy = 1'b1;
        step();
        rst_n = 1'b1;

        // Random traffic on a small register set to provoke hazards
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            set_id($urandom_range(0, 3) != 0,
                   $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 1));
            s_rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        rst_n = 1'b1;
        idle();
        s_rdy = 1'b1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
